// File: rtl/load_scoreboard_pkg.sv
// Shared core types used by the load scoreboard.
//   regaddr_t   architectural register address
//   mem_op_e    memory operation class of an ID-stage instruction
//   sb_cnt_t    outstanding-load count at the default queue depth
//   reg_match   register-address equality qualified by a "used" flag
package types;

  localparam int unsigned NumRegs          = 32;
  localparam int unsigned RegAddrW         = $clog2(NumRegs);
  localparam int unsigned SbMaxPending     = 4;
  localparam int unsigned SbCntW           = $clog2(SbMaxPending + 1);

  typedef logic [RegAddrW-1:0] regaddr_t;
  typedef logic [SbCntW-1:0]   sb_cnt_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  function automatic logic reg_match(regaddr_t a, regaddr_t b, logic used);
    return used && (a == b);
  endfunction

endpackage

// File: rtl/load_scoreboard_sb_counter.sv
// Saturating up/down counter for outstanding loads.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc, dec    count up / down this cycle (both: unchanged)
//   cnt         current count, 0..MAX
//   err         pulses when an increment at MAX or a decrement at 0 is requested
module sb_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && dec) begin
      // The return being matched had nothing to retire.
      err = (cnt_q == '0);
    end else if (inc) begin
      if (cnt_q == W'(MAX)) err = 1'b1;
      else                  cnt_d = cnt_q + W'(1);
    end else if (dec) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: tracks every in-flight load with a per-register busy
// bitmap and a pending counter, and stalls ID on RAW, WAW or a full load queue.
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                ID-stage instruction (validity, mem op, sources, dest)
//   flush               ID instruction squashed this cycle
//   ld_ret_valid/_rd    LSU load writeback return
//   load_hazard         stall IA and IF/ID, insert NOP into ID/EX
//   busy_vec            per-register busy bitmap
//   pending_cnt         loads in flight
//   sb_error            sticky protocol-error flag
module load_scoreboard
  import types::*;
#(
  parameter int unsigned NUM_SRC            = 2,
  parameter int unsigned NUM_REGS           = 32,
  parameter int unsigned REG_ADDR_W         = $clog2(NUM_REGS),
  parameter int unsigned MAX_PENDING        = 4,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1,
  parameter bit          WB_BYPASS          = 1'b1,
  parameter int unsigned CNT_W              = $clog2(MAX_PENDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  mem_op_e                       id_mem_op,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_rd_we,
  input  logic                          flush,
  input  logic                          ld_ret_valid,
  input  logic [REG_ADDR_W-1:0]         ld_ret_rd,
  output logic                          load_hazard,
  output logic [NUM_REGS-1:0]           busy_vec,
  output logic [CNT_W-1:0]              pending_cnt,
  output logic                          sb_error
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;
  logic                src_hazard, waw_hazard, cap_hazard;
  logic                issue, cnt_err, ret_err;

  // A register blocks ID when it is busy, unless it is the hardwired zero or
  // its data is being forwarded from this cycle's return.
  function automatic logic blocked(logic [NUM_REGS-1:0] busy, logic [REG_ADDR_W-1:0] a,
                                   logic ret_v, logic [REG_ADDR_W-1:0] ret_rd);
    logic hit;
    hit = busy[a];
    if (ZERO_REG_HARDWIRED && (a == '0)) hit = 1'b0;
    if (WB_BYPASS && reg_match(regaddr_t'(ret_rd), regaddr_t'(a), ret_v)) hit = 1'b0;
    return hit;
  endfunction

  always_comb begin
    src_hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] &&
          blocked(busy_q, id_src_addr[k*REG_ADDR_W +: REG_ADDR_W], ld_ret_valid, ld_ret_rd)) begin
        src_hazard = 1'b1;
      end
    end
    waw_hazard  = id_rd_we && blocked(busy_q, id_rd_addr, ld_ret_valid, ld_ret_rd);
    // A same-cycle return frees a slot, so a full queue does not stall then.
    cap_hazard  = (id_mem_op == MEM_OP_LOAD) && (pending_cnt == CNT_W'(MAX_PENDING)) &&
                  !ld_ret_valid;
    load_hazard = id_valid && !flush && (src_hazard || waw_hazard || cap_hazard);
  end

  assign issue = id_valid && !flush && !load_hazard && (id_mem_op == MEM_OP_LOAD) && id_rd_we;

  always_comb begin
    busy_d = busy_q;
    if (ld_ret_valid) busy_d[ld_ret_rd] = 1'b0;
    // Set after clear: a new load to the returning register stays busy.
    if (issue && !(ZERO_REG_HARDWIRED && (id_rd_addr == '0))) busy_d[id_rd_addr] = 1'b1;
    if (ZERO_REG_HARDWIRED) busy_d[0] = 1'b0;
  end

  assign ret_err = ld_ret_valid && !busy_q[ld_ret_rd] &&
                   !(ZERO_REG_HARDWIRED && (ld_ret_rd == '0));
  assign err_d   = err_q || ret_err || cnt_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  sb_counter #(
    .MAX (MAX_PENDING),
    .W   (CNT_W)
  ) u_sb_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (issue),
    .dec   (ld_ret_valid),
    .cnt   (pending_cnt),
    .err   (cnt_err)
  );

  assign busy_vec = busy_q;
  assign sb_error = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed self-checking bench for load_scoreboard at default parameters.
// Inputs change at the falling edge; combinational outputs are checked 1ns
// later, registered state at the following falling edge.
module tb_load_scoreboard;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  mem_op_e     id_mem_op;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we;
  logic        flush;
  logic        ld_ret_valid;
  logic [4:0]  ld_ret_rd;
  logic        load_hazard;
  logic [31:0] busy_vec;
  logic [2:0]  pending_cnt;
  logic        sb_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_mem_op    (id_mem_op),
    .id_src_addr  (id_src_addr),
    .id_src_used  (id_src_used),
    .id_rd_addr   (id_rd_addr),
    .id_rd_we     (id_rd_we),
    .flush        (flush),
    .ld_ret_valid (ld_ret_valid),
    .ld_ret_rd    (ld_ret_rd),
    .load_hazard  (load_hazard),
    .busy_vec     (busy_vec),
    .pending_cnt  (pending_cnt),
    .sb_error     (sb_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_mem_op    = MEM_OP_NONE;
    id_src_addr  = '0;
    id_src_used  = '0;
    id_rd_addr   = '0;
    id_rd_we     = 1'b0;
    flush        = 1'b0;
    ld_ret_valid = 1'b0;
    ld_ret_rd    = '0;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    idle();
    id_valid   = 1'b1;
    id_mem_op  = MEM_OP_LOAD;
    id_rd_addr = rd;
    id_rd_we   = 1'b1;
  endtask

  task automatic ret(input logic [4:0] rd);
    idle();
    ld_ret_valid = 1'b1;
    ld_ret_rd    = rd;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    chk("rst_err", 32'(sb_error), 32'd0);
    chk("rst_hazard", 32'(load_hazard), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // RAW on r5 and same-cycle return bypass
    issue_load(5'd5);
    #1 chk("ld5_nohaz", 32'(load_hazard), 32'd0);
    @(negedge clk);
    chk("ld5_busy", busy_vec, 32'h20);
    chk("ld5_cnt", 32'(pending_cnt), 32'd1);
    idle();
    id_valid    = 1'b1;
    id_src_addr = 10'd5;
    id_src_used = 2'b01;
    #1 chk("raw5_haz", 32'(load_hazard), 32'd1);
    ld_ret_valid = 1'b1;
    ld_ret_rd    = 5'd5;
    #1 chk("raw5_bypass", 32'(load_hazard), 32'd0);
    @(negedge clk);
    chk("ret5_busy", busy_vec, 32'h0);
    chk("ret5_cnt", 32'(pending_cnt), 32'd0);

    // Fill the load queue, then a fifth load
    for (int r = 1; r <= 4; r++) begin
      issue_load(5'(r));
      @(negedge clk);
    end
    chk("full_cnt", 32'(pending_cnt), 32'd4);
    chk("full_busy", busy_vec, 32'h1E);
    issue_load(5'd6);
    #1 chk("cap_haz", 32'(load_hazard), 32'd1);
    ld_ret_valid = 1'b1;
    ld_ret_rd    = 5'd1;
    #1 chk("cap_ret_nohaz", 32'(load_hazard), 32'd0);
    @(negedge clk);
    chk("cap_cnt", 32'(pending_cnt), 32'd4);
    chk("cap_busy", busy_vec, 32'h5C);
    ret(5'd2); @(negedge clk);
    ret(5'd3); @(negedge clk);
    ret(5'd4); @(negedge clk);
    ret(5'd6); @(negedge clk);
    idle();
    chk("drain_cnt", 32'(pending_cnt), 32'd0);
    chk("drain_busy", busy_vec, 32'h0);
    chk("drain_err", 32'(sb_error), 32'd0);

    // WAW stall on r7, suppressed by flush
    issue_load(5'd7);
    @(negedge clk);
    idle();
    id_valid   = 1'b1;
    id_rd_addr = 5'd7;
    id_rd_we   = 1'b1;
    #1 chk("waw_haz", 32'(load_hazard), 32'd1);
    flush = 1'b1;
    #1 chk("waw_flush", 32'(load_hazard), 32'd0);
    @(negedge clk);
    chk("flush_busy", busy_vec, 32'h80);
    chk("flush_cnt", 32'(pending_cnt), 32'd1);
    ret(5'd7);
    @(negedge clk);

    // Load to hardwired r0
    issue_load(5'd0);
    @(negedge clk);
    chk("r0_busy", busy_vec, 32'h0);
    chk("r0_cnt", 32'(pending_cnt), 32'd1);
    idle();
    id_valid    = 1'b1;
    id_src_addr = 10'd0;
    id_src_used = 2'b11;
    #1 chk("r0_read", 32'(load_hazard), 32'd0);
    ret(5'd0);
    @(negedge clk);
    chk("r0_ret_cnt", 32'(pending_cnt), 32'd0);
    chk("r0_ret_err", 32'(sb_error), 32'd0);

    // Return with nothing in flight
    ret(5'd3);
    @(negedge clk);
    chk("uf_err", 32'(sb_error), 32'd1);
    chk("uf_cnt", 32'(pending_cnt), 32'd0);
    issue_load(5'd9);  @(negedge clk);
    issue_load(5'd10); @(negedge clk);
    issue_load(5'd11); @(negedge clk);
    chk("sticky_err", 32'(sb_error), 32'd1);
    chk("three_cnt", 32'(pending_cnt), 32'd3);
    chk("three_busy", busy_vec, 32'h0E00);
    idle();
    id_valid    = 1'b1;
    id_src_addr = {5'd0, 5'd9};
    id_src_used = 2'b01;
    #1 chk("pre_rst_haz", 32'(load_hazard), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_cnt", 32'(pending_cnt), 32'd0);
    chk("arst_haz", 32'(load_hazard), 32'd0);
    chk("arst_err", 32'(sb_error), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
